// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the 5x5 convolution window pipeline.
package conv_pkg;
  localparam int IMG_W = 32;
  localparam int IMG_H = 32;
  localparam int KSIZE = 5;
  localparam int PIX_W = 8;

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int N_WIN = (IMG_W - KSIZE + 1) * (IMG_H - KSIZE + 1);
  localparam int CNT_W = $clog2(IMG_W * IMG_H) + 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } state_t;
endpackage

// File: rtl/conv_window_ctrl_if.sv
// Pixel-source, window-buffer and window-consumer signals of the window sequencer.
interface conv_window_ctrl_if #(
  parameter int PIX_W = conv_pkg::PIX_W,
  parameter int ROW_W = conv_pkg::ROW_W,
  parameter int COL_W = conv_pkg::COL_W
);
  logic [PIX_W-1:0] src_pixel;
  logic             src_valid;
  logic             src_ready;
  logic             buf_reset;
  logic [PIX_W-1:0] buf_pixel;
  logic             buf_valid;
  logic             win_valid;
  logic             win_ready;
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;

  modport master (
    input  src_pixel, src_valid, win_ready,
    output src_ready, buf_reset, buf_pixel, buf_valid, win_valid, win_row, win_col
  );

  modport slave (
    output src_pixel, src_valid, win_ready,
    input  src_ready, buf_reset, buf_pixel, buf_valid, win_valid, win_row, win_col
  );
endinterface

// File: rtl/conv_raster_cnt.sv
// Raster col/row tracker: advances one pixel per enabled cycle, sync clear has priority.
// Flags are combinational from the current (pre-increment) position.
module conv_raster_cnt #(
  parameter int IMG_W = conv_pkg::IMG_W,
  parameter int IMG_H = conv_pkg::IMG_H,
  parameter int KSIZE = conv_pkg::KSIZE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  output logic [$clog2(IMG_W)-1:0] col,
  output logic [$clog2(IMG_H)-1:0] row,
  output logic                     last_pixel,
  output logic                     in_window
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_WIN0 = COL_W'(KSIZE - 1);
  localparam logic [ROW_W-1:0] ROW_WIN0 = ROW_W'(KSIZE - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (en) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col        = col_q;
  assign row        = row_q;
  assign last_pixel = (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign in_window  = (col_q >= COL_WIN0) && (row_q >= ROW_WIN0);
endmodule

// File: rtl/conv_window_ctrl.sv
// Frame sequencer for the 5x5 window buffer; window valid 1 cycle after its qualifying push,
// src_ready drops while a window is pending and unconsumed. CONV_WIN_COUNT_EN adds win_count.
module conv_window_ctrl #(
  parameter int IMG_W = conv_pkg::IMG_W,
  parameter int IMG_H = conv_pkg::IMG_H,
  parameter int KSIZE = conv_pkg::KSIZE,
  parameter int PIX_W = conv_pkg::PIX_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  output logic                             busy,
  output logic                             done,
`ifdef CONV_WIN_COUNT_EN
  output logic [$clog2(IMG_W*IMG_H):0]     win_count,
`endif
  conv_window_ctrl_if.master               bus
);
  import conv_pkg::*;

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_OFS = COL_W'(KSIZE / 2);
  localparam logic [ROW_W-1:0] ROW_OFS = ROW_W'(KSIZE / 2);

  state_t           state_q, state_d;
  logic             pending_q, pending_d;
  logic             buf_reset_q, buf_reset_d;
  logic [ROW_W-1:0] win_row_q, win_row_d;
  logic [COL_W-1:0] win_col_q, win_col_d;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             last_pixel;
  logic             in_window;
  logic             abort_hit;
  logic             push;
  logic             consume;

  assign abort_hit     = abort && (state_q == CLEAR || state_q == STREAM || state_q == DRAIN);
  // Abort wins over a same-cycle push, so the pixel is refused outright.
  assign bus.src_ready = (state_q == STREAM) && !abort && (!pending_q || bus.win_ready);
  assign push          = bus.src_valid && bus.src_ready;
  assign consume       = pending_q && bus.win_ready;

  conv_raster_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .KSIZE (KSIZE)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr        (state_q == CLEAR),
    .en         (push),
    .col        (col),
    .row        (row),
    .last_pixel (last_pixel),
    .in_window  (in_window)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    win_row_d = win_row_q;
    win_col_d = win_col_q;

    unique case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = STREAM;
      STREAM:  if (push && last_pixel) state_d = DRAIN;
      DRAIN:   if (!pending_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new window replaces a consumed one in the same cycle without a bubble.
    if (push && in_window) begin
      pending_d = 1'b1;
      win_row_d = row - ROW_OFS;
      win_col_d = col - COL_OFS;
    end else if (consume) begin
      pending_d = 1'b0;
    end

    if (abort_hit) begin
      state_d   = IDLE;
      pending_d = 1'b0;
    end

    buf_reset_d = (state_d == CLEAR) || abort_hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      buf_reset_q <= 1'b1;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      buf_reset_q <= buf_reset_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

`ifdef CONV_WIN_COUNT_EN
  logic [$clog2(IMG_W*IMG_H):0] win_count_q, win_count_d;

  always_comb begin
    win_count_d = win_count_q;
    if (state_q == CLEAR) win_count_d = '0;
    else if (consume)     win_count_d = win_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) win_count_q <= '0;
    else        win_count_q <= win_count_d;
  end

  assign win_count = win_count_q;
`endif

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign bus.buf_reset = buf_reset_q;
  assign bus.buf_pixel = bus.src_pixel;
  assign bus.buf_valid = push;
  assign bus.win_valid = pending_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;
endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed frames against conv_window_ctrl with a window scoreboard fed from observed pushes.
module tb_conv_window_ctrl;
  import conv_pkg::*;

  localparam int FIRST_IDX = (KSIZE - 1) * IMG_W + (KSIZE - 1);

  typedef struct packed {
    logic [ROW_W-1:0] r;
    logic [COL_W-1:0] c;
  } win_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy;
  logic done;
`ifdef CONV_WIN_COUNT_EN
  logic [CNT_W-1:0] win_count;
`endif

  conv_window_ctrl_if #(.PIX_W(PIX_W), .ROW_W(ROW_W), .COL_W(COL_W)) bus ();

  conv_window_ctrl #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .KSIZE (KSIZE),
    .PIX_W (PIX_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
`ifdef CONV_WIN_COUNT_EN
    .win_count (win_count),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // Scoreboard state, owned by the monitor.
  win_t sb[$];
  win_t last_win;
  int   m_row, m_col, push_cnt, hs_cnt, done_cnt;
  bit   exp_pend, first_seen;

  always @(negedge clk) begin
    bit   nxt;
    win_t e;
    if (!reset) begin
      m_row = 0; m_col = 0; push_cnt = 0; hs_cnt = 0;
      exp_pend = 0; first_seen = 0; sb.delete();
    end else begin
      check("win_valid", bus.win_valid, exp_pend);
      check("buf_pixel", bus.buf_pixel, bus.src_pixel);
      if (!busy) check("idle_src_ready", bus.src_ready, 0);
      nxt = exp_pend;
      if (bus.win_valid && !first_seen) begin
        first_seen = 1;
        check("first_win_latency", push_cnt, FIRST_IDX + 1);
      end
      if (bus.win_valid && !bus.win_ready) check("bp_src_ready", bus.src_ready, 0);
      if (bus.win_valid && bus.win_ready) begin
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("win_row", bus.win_row, e.r);
          check("win_col", bus.win_col, e.c);
        end
        if (hs_cnt == 0) begin
          check("first_win_row", bus.win_row, KSIZE / 2);
          check("first_win_col", bus.win_col, KSIZE / 2);
        end
        last_win = '{r: bus.win_row, c: bus.win_col};
        hs_cnt++;
        nxt = 0;
      end
      if (abort && busy) begin
        check("abort_blocks_push", bus.buf_valid, 0);
        nxt = 0;
        sb.delete();
      end else if (bus.buf_valid) begin
        if (m_row >= KSIZE - 1 && m_col >= KSIZE - 1) begin
          sb.push_back('{r: ROW_W'(m_row - KSIZE / 2), c: COL_W'(m_col - KSIZE / 2)});
          nxt = 1;
        end
        m_col++;
        if (m_col == IMG_W) begin
          m_col = 0;
          m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
        end
        push_cnt++;
      end
      if (done) done_cnt++;
      exp_pend = nxt;
      if (bus.buf_reset) begin
        m_row = 0; m_col = 0; push_cnt = 0; hs_cnt = 0;
        exp_pend = 0; first_seen = 0; sb.delete();
      end
    end
  end

  task automatic run_frame(input string tag, input bit gaps, input bit toggle,
                           input int abort_at, input bit poke_start);
    int d0;
    int cyc;
    bit aborted;
    d0      = done_cnt;
    cyc     = 0;
    aborted = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 8000) begin
      bus.src_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.src_pixel = PIX_W'($urandom);
      bus.win_ready = toggle ? !bus.win_ready : 1'b1;
      start = poke_start && (cyc == 300);
      abort = (abort_at >= 0) && (push_cnt == abort_at);
      @(posedge clk); #1;
      cyc++;
      if (abort) begin
        abort   = 1'b0;
        aborted = 1;
        check({tag, "_abort_busy"}, busy, 0);
        check({tag, "_abort_buf_reset"}, bus.buf_reset, 1);
        check({tag, "_abort_done"}, done, 0);
        break;
      end
      if (done_cnt != d0) break;
    end
    start = 1'b0;
    bus.src_valid = 1'b0;
    check({tag, "_no_timeout"}, cyc < 8000, 1);
    repeat (3) @(posedge clk);
    #1;
    if (aborted) begin
      check({tag, "_abort_no_done"}, done_cnt - d0, 0);
      check({tag, "_abort_idle"}, busy, 0);
    end else begin
      check({tag, "_done_pulses"}, done_cnt - d0, 1);
      check({tag, "_pushes"}, push_cnt, IMG_W * IMG_H);
      check({tag, "_windows"}, hs_cnt, N_WIN);
      check({tag, "_last_row"}, last_win.r, IMG_H - 1 - KSIZE / 2);
      check({tag, "_last_col"}, last_win.c, IMG_W - 1 - KSIZE / 2);
      check({tag, "_sb_empty"}, sb.size(), 0);
      check({tag, "_idle"}, busy, 0);
`ifdef CONV_WIN_COUNT_EN
      check({tag, "_win_count"}, win_count, N_WIN);
`endif
    end
  endtask

  initial begin
    bus.src_valid = 1'b1;
    bus.src_pixel = '0;
    bus.win_ready = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_src_ready", bus.src_ready, 0);
    check("rst_buf_valid", bus.buf_valid, 0);
    check("rst_win_valid", bus.win_valid, 0);
    check("rst_buf_reset", bus.buf_reset, 1);
    check("rst_win_row", bus.win_row, 0);
    check("rst_win_col", bus.win_col, 0);
    bus.src_valid = 1'b0;
    #20 reset = 1'b1;
    @(posedge clk); #1;
    check("idle_buf_reset", bus.buf_reset, 0);
    check("idle_busy", busy, 0);

    run_frame("f_full", 0, 0, -1, 0);
    run_frame("f_toggle", 1, 1, -1, 0);
    run_frame("f_abort", 0, 0, 500, 0);
    run_frame("f_after_abort", 0, 0, -1, 0);
    run_frame("f_start_poke", 0, 0, -1, 1);

`ifdef CONV_WIN_COUNT_EN
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("win_count_cleared", win_count, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`endif

    // Asynchronous reset between clock edges while streaming.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bus.src_valid = 1'b1;
    bus.win_ready = 1'b1;
    repeat (200) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_src_ready", bus.src_ready, 0);
    check("arst_buf_valid", bus.buf_valid, 0);
    check("arst_win_valid", bus.win_valid, 0);
    check("arst_buf_reset", bus.buf_reset, 1);
    check("arst_win_row", bus.win_row, 0);
    check("arst_win_col", bus.win_col, 0);
    #4 reset = 1'b1;
    bus.src_valid = 1'b0;
    @(posedge clk); #1;
    check("arst_release_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
